sd_block_arbiter: RTL and testbench
===================================

Name: sd_block_arbiter

Overview:
- Parametrised successor to the single-channel HDD request/ack sequencer in the emu top level.
- Serves NUM_CH block-device clients (floppy tracks, HDDs) against the hps_io per-drive sd_rd/sd_wr/sd_ack handshake.
- Latches read/write request pulses per channel and grants one transfer at a time, round-robin.
- Drives per-channel LBA and a CPU wait line, rejects unmounted drives, and times out stalled transfers with an error flag.

Parameters:
- NUM_CH, 3, number of virtual drives (maps to hps_io VDNUM).
- LBA_W, 32, sector address width.
- TMO_W, 24, timeout counter width.
- TMO_CYCLES, 24'hFFFFFF, clk_sys cycles allowed from sd_rd/sd_wr assertion to sd_ack rise.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous flush (warm/cold reset from OSD).
- req_rd  in  NUM_CH  one-cycle read request pulse per channel.
- req_wr  in  NUM_CH  one-cycle write request pulse per channel.
- req_lba  in  NUM_CH*LBA_W  sector per channel; sampled on grant.
- mounted  in  NUM_CH  image present per channel (level).
- sd_lba  out  NUM_CH*LBA_W  per-channel LBA to hps_io.
- sd_rd  out  NUM_CH  read strobe to hps_io.
- sd_wr  out  NUM_CH  write strobe to hps_io.
- sd_ack  in  NUM_CH  hps_io acknowledge, high for the whole buffer transfer.
- busy  out  NUM_CH  channel has a pending or active op.
- done  out  NUM_CH  one-cycle completion pulse.
- err  out  NUM_CH  one-cycle pulse together with done on timeout or unmounted drive.
- cpu_wait  out  1  high while any op is pending or active.
- active_ch  out  $clog2(NUM_CH)  channel currently granted (valid when not IDLE).

Behaviour:
- Reset (reset_n=0, async): all outputs 0; state IDLE; pending bits cleared; rr pointer 0; sd_lba 0.
- abort=1 (sync): same as reset, except sd_lba holds its value. Takes priority over all events in that cycle.
- Pending latch: pend_rd[i] |= req_rd[i]; pend_wr[i] |= req_wr[i]. Latching happens every cycle, including while channel i is active.
  - A pulse arriving on the cycle its bit clears re-sets it; that request is not lost.
  - rd and wr pending on the same channel: read is serviced first, write on a later grant.
- busy[i] = pend_rd[i] | pend_wr[i] | (state != IDLE && active_ch == i).
- cpu_wait = |busy, registered. It rises the cycle after the first request pulse.
- FSM states: IDLE, ISSUE, XFER, FIN.
  - IDLE: pick the first channel with a pending bit, searching from rr pointer upward with wrap. Register active_ch, op (rd if pend_rd), and sd_lba[ch] <= req_lba[ch]. Go to ISSUE next cycle. If none pending, stay.
  - ISSUE, mounted[ch]=0: do not strobe; clear the op's pending bit; go to FIN with err.
  - ISSUE, mounted: assert sd_rd[ch] or sd_wr[ch] and load the timeout counter.
    - On sd_ack[ch] rise (registered edge detect): deassert the strobe, clear the op's pending bit, go to XFER.
    - On counter reaching 0: deassert the strobe, clear the pending bit, go to FIN with err.
  - XFER: wait for the sd_ack[ch] fall, then go to FIN. No timeout in XFER.
  - FIN: one-cycle done[ch], and err[ch] if flagged; rr <= ch+1 mod NUM_CH; go to IDLE.
- Latency, mounted channel, ack after k cycles: request pulse t0 → grant t1 → strobe t2 → done 1 cycle after the ack fall is seen. Minimum 2 idle cycles between back-to-back grants (FIN, IDLE).
- sd_lba[ch] is stable from ISSUE until the next grant of that channel. Other channels' sd_lba are untouched.
- Spurious sd_ack on a non-granted channel is ignored.
- mounted dropping during XFER: the transfer still completes normally; mounted is checked only at ISSUE.
- Only one sd_rd/sd_wr bit may be high at any time; the bench asserts this.

Decomposition:
- Package sd_arb_pkg: state enum (IDLE/ISSUE/XFER/FIN), op enum (OP_RD/OP_WR), and a function rr_pick(pending, ptr) returning the next index.
- One sub-module, sd_arb_rr: combinational round-robin picker, parametrised on NUM_CH; outputs found and index.
- The timeout counter and FSM stay in the top module.

Test Plan:
- Single read: ch1 mounted, req_rd[1] pulse at t0, LBA 0x1234, ack high t5–t20 → sd_rd[1]=1 from t2 to the cycle after the ack rise; sd_lba[1]=0x1234; done[1] at t22; err 0; cpu_wait 1 from t1 to t22.
- Round-robin: req_rd on ch0, ch1, ch2 in the same cycle, rr=0 → grants in order 0,1,2. Then requests on ch0 and ch2 with rr=0 → ch0 first; a later simultaneous pair starting from rr=1 → ch2 before ch0.
- Unmounted: req_wr[2] with mounted[2]=0 → no sd_wr strobe; done[2]=err[2]=1 at t3; busy[2] clears.
- Timeout: TMO_CYCLES=16, ack never rises → strobe high 16 cycles then drops; done+err pulse; the next pending channel is granted afterward.
- Same-channel rd+wr plus re-request: req_rd[0] and req_wr[0] together, and a new req_rd[0] during XFER → order read, write, read; three done pulses, no request lost.
- Abort and reset mid-XFER: abort during XFER → strobes 0, pending cleared, cpu_wait 0 next cycle, no done pulse. reset_n low asynchronously → outputs 0 immediately.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the block-device request arbiter.
package sd_arb_pkg;

   // Upper bound on channels the round-robin helper can scan.
   localparam int MAX_CH   = 16;
   localparam int MAX_CH_W = 4;

   // Debug encoding of the FSM is this enum's value (IDLE=0 .. FIN=3).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      FIN   = 2'd3
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // First set bit of pending[0..n-1], scanning from ptr upward with wrap.
   // Returns 0 when nothing is pending; callers qualify with |pending.
   function automatic int rr_pick(input logic [MAX_CH-1:0] pending,
                                  input int ptr, input int n);
      int   idx;
      int   pick;
      logic hit;
      pick = 0;
      hit  = 1'b0;
      for (int k = 0; k < MAX_CH; k++) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!hit && pending[idx[MAX_CH_W-1:0]]) begin
               hit  = 1'b1;
               pick = idx;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Combinational round-robin picker over the per-channel pending vector.
module sd_arb_rr
   import sd_arb_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] pend_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic              found_o,
   output logic [CH_W-1:0]   idx_o
);

   logic [MAX_CH-1:0] pend_ext;

   // Widen to the helper's fixed scan width and pick from the pointer.
   always_comb begin
      pend_ext               = '0;
      pend_ext[NUM_CH-1:0]   = pend_i;
      found_o                = |pend_i;
      idx_o                  = CH_W'(rr_pick(pend_ext, int'(ptr_i), NUM_CH));
   end

endmodule

// File: rtl/sd_block_arbiter.sv
// Multi-channel block-device arbiter in front of the hps_io sd_rd/sd_wr/sd_ack
// handshake. Handshake: a strobe (sd_rd/sd_wr) is held on the granted channel
// until sd_ack rises; sd_ack then stays high for the whole buffer transfer and
// the op completes once it falls. Only one strobe bit is ever high.
module sd_block_arbiter
   import sd_arb_pkg::*;
#(
   parameter int               NUM_CH     = 3,
   parameter int               LBA_W      = 32,
   parameter int               TMO_W      = 24,
   parameter logic [TMO_W-1:0] TMO_CYCLES = 24'hFFFFFF,
   parameter int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic                    abort,
   input  logic [NUM_CH-1:0]       req_rd,
   input  logic [NUM_CH-1:0]       req_wr,
   input  logic [NUM_CH*LBA_W-1:0] req_lba,
   input  logic [NUM_CH-1:0]       mounted,
   output logic [NUM_CH*LBA_W-1:0] sd_lba,
   output logic [NUM_CH-1:0]       sd_rd,
   output logic [NUM_CH-1:0]       sd_wr,
   input  logic [NUM_CH-1:0]       sd_ack,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       err,
   output logic                    cpu_wait,
   output logic [CH_W-1:0]         active_ch,
   output logic [1:0]              dbg_state
);

   state_e                  state_q, state_d;
   op_e                     op_q, op_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [CH_W-1:0]         rr_q, rr_d;
   logic [NUM_CH-1:0]       pend_rd_q, pend_rd_d;
   logic [NUM_CH-1:0]       pend_wr_q, pend_wr_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic                    issued_q, issued_d;
   logic                    err_flag_q, err_flag_d;
   logic                    cpu_wait_q, cpu_wait_d;
   logic [NUM_CH*LBA_W-1:0] lba_q, lba_d;
   logic [NUM_CH-1:0]       ack_q;

   logic                    pick_found;
   logic [CH_W-1:0]         pick_idx;
   logic [NUM_CH-1:0]       ch_vec;
   logic [NUM_CH-1:0]       clr_rd, clr_wr;
   logic                    ack_rise, ack_fall;

   sd_arb_rr #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
      .pend_i  (pend_rd_q | pend_wr_q),
      .ptr_i   (rr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Edge detect on the granted channel's ack; other channels are ignored.
   always_comb begin
      ack_rise       = sd_ack[ch_q] & ~ack_q[ch_q];
      ack_fall       = ~sd_ack[ch_q] & ack_q[ch_q];
      ch_vec         = '0;
      ch_vec[ch_q]   = 1'b1;
   end

   // Next-state logic: grant, issue/timeout, transfer, finish; abort overrides.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      ch_d       = ch_q;
      rr_d       = rr_q;
      tmo_d      = tmo_q;
      issued_d   = issued_q;
      err_flag_d = err_flag_q;
      lba_d      = lba_q;
      clr_rd     = '0;
      clr_wr     = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               ch_d       = pick_idx;
               op_d       = pend_rd_q[pick_idx] ? OP_RD : OP_WR;
               lba_d[int'(pick_idx)*LBA_W +: LBA_W] = req_lba[int'(pick_idx)*LBA_W +: LBA_W];
               tmo_d      = TMO_CYCLES - TMO_W'(1);
               issued_d   = 1'b0;
               err_flag_d = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // Mount state only matters on the first ISSUE cycle; once the
            // strobe is up it stays up until ack or timeout.
            if (!issued_q && !mounted[ch_q]) begin
               err_flag_d = 1'b1;
               state_d    = FIN;
            end else if (ack_rise) begin
               issued_d   = 1'b0;
               state_d    = XFER;
            end else if (tmo_q == '0) begin
               issued_d   = 1'b0;
               err_flag_d = 1'b1;
               state_d    = FIN;
            end else begin
               issued_d   = 1'b1;
               tmo_d      = tmo_q - TMO_W'(1);
            end
            if (state_d != ISSUE) begin
               clr_rd = (op_q == OP_RD) ? ch_vec : '0;
               clr_wr = (op_q == OP_WR) ? ch_vec : '0;
            end
         end
         XFER: begin
            if (ack_fall) state_d = FIN;
         end
         FIN: begin
            rr_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // New pulses always land, even on the cycle their bit is cleared.
      pend_rd_d = (pend_rd_q & ~clr_rd) | req_rd;
      pend_wr_d = (pend_wr_q & ~clr_wr) | req_wr;

      if (abort) begin
         state_d    = IDLE;
         op_d       = OP_RD;
         ch_d       = '0;
         rr_d       = '0;
         tmo_d      = '0;
         issued_d   = 1'b0;
         err_flag_d = 1'b0;
         pend_rd_d  = '0;
         pend_wr_d  = '0;
         lba_d      = lba_q;
      end

      cpu_wait_d = (|(pend_rd_d | pend_wr_d)) || (state_d != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         op_q       <= OP_RD;
         ch_q       <= '0;
         rr_q       <= '0;
         pend_rd_q  <= '0;
         pend_wr_q  <= '0;
         tmo_q      <= '0;
         issued_q   <= 1'b0;
         err_flag_q <= 1'b0;
         cpu_wait_q <= 1'b0;
         lba_q      <= '0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ch_q       <= ch_d;
         rr_q       <= rr_d;
         pend_rd_q  <= pend_rd_d;
         pend_wr_q  <= pend_wr_d;
         tmo_q      <= tmo_d;
         issued_q   <= issued_d;
         err_flag_q <= err_flag_d;
         cpu_wait_q <= cpu_wait_d;
         lba_q      <= lba_d;
         ack_q      <= sd_ack;
      end
   end

   // Output decode from registered state.
   always_comb begin
      sd_rd = '0;
      sd_wr = '0;
      done  = '0;
      err   = '0;
      busy  = pend_rd_q | pend_wr_q;
      if (state_q != IDLE) busy[ch_q] = 1'b1;
      if (state_q == ISSUE && (issued_q || mounted[ch_q])) begin
         if (op_q == OP_RD) sd_rd[ch_q] = 1'b1;
         else               sd_wr[ch_q] = 1'b1;
      end
      if (state_q == FIN) begin
         done[ch_q] = 1'b1;
         err[ch_q]  = err_flag_q;
      end
   end

   assign sd_lba    = lba_q;
   assign cpu_wait  = cpu_wait_q;
   assign active_ch = ch_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Bench for sd_block_arbiter: directed timing checks plus a completion
// scoreboard fed by an automatic hps_io ack responder.
module tb_sd_block_arbiter;

   localparam int NCH = 3;
   localparam int LW  = 32;
   localparam int W   = 37;   // {ch[1:0], op[1:0] (0 none/1 rd/2 wr), err, lba[31:0]}

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd2;

   logic              clk_sys;
   logic              reset_n;
   logic              abort;
   logic [NCH-1:0]    req_rd, req_wr, mounted, sd_ack;
   logic [NCH*LW-1:0] req_lba, sd_lba;
   logic [NCH-1:0]    sd_rd, sd_wr, busy, done, err;
   logic              cpu_wait;
   logic [1:0]        active_ch;
   logic [1:0]        dbg_state;

   logic [W-1:0]      exp_q[$];
   int                n_tests;
   int                n_fail;

   logic              auto_ack;
   logic [NCH-1:0]    ack_en;
   int                ack_len_fix;

   sd_block_arbiter #(
      .NUM_CH(NCH), .LBA_W(LW), .TMO_W(24), .TMO_CYCLES(24'd16)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .abort     (abort),
      .req_rd    (req_rd),
      .req_wr    (req_wr),
      .req_lba   (req_lba),
      .mounted   (mounted),
      .sd_lba    (sd_lba),
      .sd_rd     (sd_rd),
      .sd_wr     (sd_wr),
      .sd_ack    (sd_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cpu_wait  (cpu_wait),
      .active_ch (active_ch),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_rec(input int ch, input int op, input logic e,
                                           input logic [31:0] lba);
      return {ch[1:0], op[1:0], e, lba};
   endfunction

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr);
      req_rd = rd;
      req_wr = wr;
      step();
      req_rd = '0;
      req_wr = '0;
   endtask

   task automatic set_lba(input int ch, input logic [31:0] v);
      req_lba[ch*LW +: LW] = v;
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || cpu_wait) && guard < 2000) begin
         @(negedge clk_sys);
         guard++;
      end
      check(tag, exp_q.size(), 0);
      step();
   endtask

   task automatic wait_state(input logic [1:0] s, input string tag);
      int guard;
      guard = 0;
      do begin
         @(negedge clk_sys);
         guard++;
      end while (dbg_state != s && guard < 200);
      check(tag, dbg_state, s);
   endtask

   // ---------------- hps_io ack responder ----------------
   initial begin
      int rc, dly, len;
      forever begin
         @(negedge clk_sys);
         if (auto_ack && reset_n && (((sd_rd | sd_wr) & ack_en) != '0)) begin
            rc = 0;
            for (int i = 0; i < NCH; i++)
               if ((sd_rd[i] || sd_wr[i]) && ack_en[i]) rc = i;
            dly = $urandom_range(1, 4);
            len = (ack_len_fix != 0) ? ack_len_fix : $urandom_range(1, 6);
            repeat (dly) @(posedge clk_sys);
            #1 sd_ack[rc] = 1'b1;
            repeat (len) @(posedge clk_sys);
            #1 sd_ack[rc] = 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [1:0]  obs_op;
      int          obs_ch, dch;
      logic [31:0] obs_lba, lba_v;
      logic [W-1:0] e, o;
      obs_op = 2'd0; obs_ch = 0; obs_lba = '0;
      forever begin
         @(negedge clk_sys);
         if (!reset_n || abort) begin
            obs_op = 2'd0;
         end else begin
            if ((sd_rd | sd_wr) != '0) begin
               check("strobe_onehot", $onehot(sd_rd | sd_wr), 1'b1);
               for (int i = 0; i < NCH; i++)
                  if (sd_rd[i] || sd_wr[i]) begin
                     obs_ch  = i;
                     obs_op  = sd_rd[i] ? 2'd1 : 2'd2;
                     obs_lba = sd_lba[i*LW +: LW];
                  end
            end
            if ((err & ~done) != '0) check("err_without_done", err, done);
            if (done != '0) begin
               check("done_onehot", $onehot(done), 1'b1);
               dch = 0;
               for (int i = NCH - 1; i >= 0; i--) if (done[i]) dch = i;
               lba_v = (obs_op != 2'd0 && obs_ch == dch) ? obs_lba : sd_lba[dch*LW +: LW];
               o = mk_rec(dch, (obs_ch == dch) ? int'(obs_op) : 0, err[dch], lba_v);
               if (exp_q.size() == 0) begin
                  check("unexpected_done", done, '0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_done", o, e);
               end
               obs_op = 2'd0;
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] l0, l1, l2;
      int cnt, guard;
      n_tests = 0; n_fail = 0;
      reset_n = 1'b0; abort = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0;
      mounted = 3'b111; sd_ack = '0; auto_ack = 1'b0; ack_en = 3'b111; ack_len_fix = 0;

      repeat (3) @(negedge clk_sys);
      check("rst_strobes", {sd_rd, sd_wr}, '0);
      check("rst_busy", busy, '0);
      check("rst_wait", cpu_wait, 1'b0);
      check("rst_done_err", {done, err}, '0);
      check("rst_lba", |sd_lba, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (2) step();

      // Single read on ch1, ack driven by hand t5..t20, spurious ch0 ack at t3.
      set_lba(1, 32'h1234);
      exp_q.push_back(mk_rec(1, 1, 1'b0, 32'h1234));
      req_rd = 3'b010;
      @(negedge clk_sys); check("sr_t0_wait", cpu_wait, 1'b0);
      step(); req_rd = '0;
      @(negedge clk_sys);
      check("sr_t1_wait", cpu_wait, 1'b1);
      check("sr_t1_busy", busy, 3'b010);
      check("sr_t1_rd", sd_rd, 3'b000);
      step();
      @(negedge clk_sys);
      check("sr_t2_rd", sd_rd, 3'b010);
      check("sr_t2_lba", sd_lba[63:32], 32'h1234);
      step(); sd_ack[0] = 1'b1;
      @(negedge clk_sys); check("sr_t3_rd", sd_rd, 3'b010);
      step(); sd_ack[0] = 1'b0;
      @(negedge clk_sys); check("sr_t4_rd", sd_rd, 3'b010);
      step(); sd_ack[1] = 1'b1;
      @(negedge clk_sys); check("sr_t5_rd", sd_rd, 3'b010);
      step();
      @(negedge clk_sys);
      check("sr_t6_rd", sd_rd, 3'b000);
      check("sr_t6_active", active_ch, 2'd1);
      repeat (15) step();
      sd_ack[1] = 1'b0;
      @(negedge clk_sys);
      check("sr_t21_done", done, 3'b000);
      check("sr_t21_wait", cpu_wait, 1'b1);
      step();
      @(negedge clk_sys);
      check("sr_t22_done", done, 3'b010);
      check("sr_t22_err", err, 3'b000);
      check("sr_t22_wait", cpu_wait, 1'b1);
      step();
      @(negedge clk_sys);
      check("sr_t23_wait", cpu_wait, 1'b0);
      check("sr_t23_busy", busy, 3'b000);
      step();

      // Unmounted write on ch2.
      mounted = 3'b011;
      l2 = $urandom;
      set_lba(2, l2);
      exp_q.push_back(mk_rec(2, 0, 1'b1, l2));
      pulse(3'b000, 3'b100);
      @(negedge clk_sys); step();
      @(negedge clk_sys); check("um_t2_strobe", {sd_rd, sd_wr}, '0);
      step();
      @(negedge clk_sys);
      check("um_t3_done", done, 3'b100);
      check("um_t3_err", err, 3'b100);
      check("um_t3_wr", sd_wr, 3'b000);
      step();
      @(negedge clk_sys); check("um_t4_busy", busy, 3'b000);
      step();
      mounted = 3'b111;

      // Timeout on ch1 (never acked), then ch2 served.
      auto_ack = 1'b1; ack_en = 3'b101;
      l1 = $urandom; l2 = $urandom;
      set_lba(1, l1); set_lba(2, l2);
      exp_q.push_back(mk_rec(1, 1, 1'b1, l1));
      exp_q.push_back(mk_rec(2, 1, 1'b0, l2));
      pulse(3'b110, 3'b000);
      cnt = 0; guard = 0;
      while (!done[1] && guard < 200) begin
         @(negedge clk_sys);
         if (sd_rd[1]) cnt++;
         guard++;
      end
      check("tmo_done_seen", done[1], 1'b1);
      check("tmo_strobe_cycles", cnt, 16);
      drain("tmo_drain");
      ack_en = 3'b111;

      // Round-robin ordering.
      l0 = $urandom; l1 = $urandom; l2 = $urandom;
      set_lba(0, l0); set_lba(1, l1); set_lba(2, l2);
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      exp_q.push_back(mk_rec(1, 1, 1'b0, l1));
      exp_q.push_back(mk_rec(2, 1, 1'b0, l2));
      pulse(3'b111, 3'b000);
      drain("rr_all_drain");
      exp_q.push_back(mk_rec(0, 2, 1'b0, l0));
      exp_q.push_back(mk_rec(2, 2, 1'b0, l2));
      pulse(3'b000, 3'b101);
      drain("rr_02_drain");
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      pulse(3'b001, 3'b000);
      drain("rr_0_drain");
      exp_q.push_back(mk_rec(2, 1, 1'b0, l2));
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      pulse(3'b101, 3'b000);
      drain("rr_20_drain");

      // Same-channel rd+wr, re-request read during the write's XFER.
      ack_len_fix = 4;
      l0 = $urandom;
      set_lba(0, l0);
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      exp_q.push_back(mk_rec(0, 2, 1'b0, l0));
      pulse(3'b001, 3'b001);
      guard = 0;
      do begin
         @(negedge clk_sys);
         guard++;
      end while (!sd_wr[0] && guard < 200);
      check("rw_wr_seen", sd_wr[0], 1'b1);
      wait_state(S_XFER, "rw_wr_xfer");
      step();
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      pulse(3'b001, 3'b000);
      drain("rw_drain");

      // Abort mid-XFER: everything flushed, no completion.
      ack_len_fix = 6;
      l1 = $urandom;
      set_lba(1, l1);
      pulse(3'b010, 3'b100);
      wait_state(S_XFER, "ab_xfer");
      step(); abort = 1'b1;
      step(); abort = 1'b0;
      @(negedge clk_sys);
      check("ab_strobes", {sd_rd, sd_wr}, '0);
      check("ab_busy", busy, '0);
      check("ab_wait", cpu_wait, 1'b0);
      check("ab_state", dbg_state, S_IDLE);
      check("ab_lba_hold", sd_lba[63:32], l1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         if (done != '0) cnt++;
      end
      check("ab_no_done", cnt, 0);
      step();

      // Asynchronous reset mid-XFER on ch2.
      l2 = $urandom;
      set_lba(2, l2);
      pulse(3'b100, 3'b000);
      wait_state(S_XFER, "rs_xfer");
      #2 reset_n = 1'b0;
      #1;
      check("rs_strobes", {sd_rd, sd_wr}, '0);
      check("rs_busy", busy, '0);
      check("rs_wait", cpu_wait, 1'b0);
      check("rs_active", active_ch, 2'd0);
      check("rs_lba", |sd_lba, 1'b0);
      check("rs_state", dbg_state, S_IDLE);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (20) step();

      // Recovery read after reset.
      ack_len_fix = 0;
      l0 = $urandom;
      set_lba(0, l0);
      exp_q.push_back(mk_rec(0, 1, 1'b0, l0));
      pulse(3'b001, 3'b000);
      drain("rec_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
